// File: rtl/flash_playback_pkg.sv
// Shared types and defaults for the flash playback sequencer.
// Direction encodings are text macros so both RTL files compare against the same values.
`ifndef FLASH_PLAYBACK_PKG_SV
`define FLASH_PLAYBACK_PKG_SV

`define DIR_UP   1'b1
`define DIR_DOWN 1'b0

package flash_playback_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    TICK_A,
    TICK_B
  } pb_state_e;

  localparam int          DEF_ADDR_W     = 23;
  localparam logic [22:0] DEF_START_ADDR = 23'h00000;
  localparam logic [22:0] DEF_END_ADDR   = 23'h7FFFF;

endpackage

`endif

// File: rtl/playback_addr_step.sv
// Next word address for the playback region: restart target, +/-1 step, or boundary handling.
// PLAYBACK_LOOP_EN selects wrap-around at the ends; otherwise the address holds at the boundary.
module playback_addr_step
  import flash_playback_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEF_START_ADDR),
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(DEF_END_ADDR)
) (
  input  logic              dir,
  input  logic              restart_pending,
  input  logic [ADDR_W-1:0] cur_addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              at_boundary
);

  always_comb begin
    at_boundary = (dir == `DIR_UP) ? (cur_addr == END_ADDR) : (cur_addr == START_ADDR);
    if (restart_pending) begin
      next_addr = (dir == `DIR_UP) ? START_ADDR : END_ADDR;
    end else if (at_boundary) begin
`ifdef PLAYBACK_LOOP_EN
      next_addr = (dir == `DIR_UP) ? START_ADDR : END_ADDR;
`else
      next_addr = cur_addr;
`endif
    end else if (dir == `DIR_UP) begin
      next_addr = cur_addr + ADDR_W'(1);
    end else begin
      next_addr = cur_addr - ADDR_W'(1);
    end
  end

endmodule

// File: rtl/flash_playback_ctrl.sv
// Flash playback sequencer: fetches 32-bit words over Avalon-MM and plays them as 16-bit samples.
// Define PLAYBACK_LOOP_EN to wrap at the region ends; by default playback stops with done=1.
module flash_playback_ctrl
  import flash_playback_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEF_START_ADDR),
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(DEF_END_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              dir,
  input  logic              restart,
  input  logic              sample_tick,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic              underrun,
  output logic              done
);

`ifdef PLAYBACK_LOOP_EN
  localparam bit STOP_AT_END = 1'b0;
`else
  localparam bit STOP_AT_END = 1'b1;
`endif

  pb_state_e         state_q, state_d;
  logic [31:0]       word_q;
  logic              word_dir_q;
  logic              restart_pending_q;
  logic              pend_eff, step_dir, tick_run;
  logic              accept, latch_word, emit_a, emit_b, step, idle_restart, underrun_d, go_done;
  logic [ADDR_W-1:0] next_addr;
  logic              at_boundary;

  assign flash_mem_byteenable = 4'b1111;
  assign tick_run = sample_tick & play;
  // A restart arriving on the stepping cycle itself still wins over the +/-1 step.
  assign pend_eff = restart_pending_q | restart;
  // Idle restarts follow the live switch; everything else follows the word's own direction.
  assign step_dir = (state_q == IDLE) ? dir : word_dir_q;

  playback_addr_step #(
    .ADDR_W    (ADDR_W),
    .START_ADDR(START_ADDR),
    .END_ADDR  (END_ADDR)
  ) u_step (
    .dir            (step_dir),
    .restart_pending(pend_eff),
    .cur_addr       (flash_mem_address),
    .next_addr      (next_addr),
    .at_boundary    (at_boundary)
  );

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    latch_word   = 1'b0;
    emit_a       = 1'b0;
    emit_b       = 1'b0;
    step         = 1'b0;
    idle_restart = 1'b0;
    underrun_d   = 1'b0;
    go_done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        idle_restart = restart;
        if (play && !done) state_d = REQ;
      end
      REQ: begin
        underrun_d = tick_run;
        if (!flash_mem_waitrequest) begin
          accept  = 1'b1;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        underrun_d = tick_run;
        if (flash_mem_readdatavalid) begin
          latch_word = 1'b1;
          state_d    = TICK_A;
        end
      end
      TICK_A: begin
        if (tick_run) begin
          emit_a  = 1'b1;
          state_d = TICK_B;
        end
      end
      TICK_B: begin
        if (tick_run) begin
          emit_b  = 1'b1;
          step    = 1'b1;
          state_d = REQ;
          if (STOP_AT_END && at_boundary && !pend_eff) begin
            go_done = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      flash_mem_read    <= 1'b0;
      flash_mem_address <= START_ADDR;
      sample_out        <= 16'h0000;
      sample_valid      <= 1'b0;
      underrun          <= 1'b0;
      done              <= 1'b0;
      word_q            <= 32'h0;
      word_dir_q        <= `DIR_UP;
      restart_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      flash_mem_read <= (state_d == REQ);
      sample_valid   <= emit_a | emit_b;
      underrun       <= underrun_d;
      if (accept)     word_dir_q <= dir;
      if (latch_word) word_q     <= flash_mem_readdata;
      if (emit_a) begin
        sample_out <= (word_dir_q == `DIR_UP) ? word_q[15:0] : word_q[31:16];
      end else if (emit_b) begin
        sample_out <= (word_dir_q == `DIR_UP) ? word_q[31:16] : word_q[15:0];
      end
      if (step || idle_restart) begin
        flash_mem_address <= next_addr;
        restart_pending_q <= 1'b0;
      end else if (restart) begin
        restart_pending_q <= 1'b1;
      end
      if (go_done)           done <= 1'b1;
      else if (idle_restart) done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flash_playback_ctrl.sv
// Self-checking bench for flash_playback_ctrl: randomized Avalon responder plus a word-level
// reference model of the playback order (address walk, half order, restart, end-of-region).
module tb_flash_playback_ctrl;

  localparam logic [22:0] START_A = 23'h000000;
  localparam logic [22:0] END_A   = 23'h00003F;

  logic        clk, reset, play, dir, restart, sample_tick;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;
  logic [15:0] sample_out;
  logic        sample_valid, underrun, done;

  flash_playback_ctrl #(
    .ADDR_W    (23),
    .START_ADDR(START_A),
    .END_ADDR  (END_A)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .play                   (play),
    .dir                    (dir),
    .restart                (restart),
    .sample_tick            (sample_tick),
    .flash_mem_read         (flash_mem_read),
    .flash_mem_address      (flash_mem_address),
    .flash_mem_byteenable   (flash_mem_byteenable),
    .flash_mem_waitrequest  (flash_mem_waitrequest),
    .flash_mem_readdata     (flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .sample_out             (sample_out),
    .sample_valid           (sample_valid),
    .underrun               (underrun),
    .done                   (done)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem [0:63];
  int          force_ws = -1;
  int          force_rdv = -1;

  // Reference model state
  logic [22:0] m_addr;
  bit          m_dir;
  bit          m_pend;
  logic [15:0] m_last;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Flash slave: 1..3 wait states, read data 1..4 cycles after acceptance.
  initial begin
    int ws_left;
    int rdv_left;
    logic [5:0] acc_addr;
    ws_left = -1;
    rdv_left = 0;
    acc_addr = '0;
    flash_mem_waitrequest = 1'b1;
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata = 32'h0;
    forever begin
      @(negedge clk);
      flash_mem_readdatavalid = 1'b0;
      if (rdv_left > 0) begin
        rdv_left--;
        if (rdv_left == 0) begin
          flash_mem_readdatavalid = 1'b1;
          flash_mem_readdata = mem[acc_addr];
        end
      end
      if (flash_mem_read) begin
        if (ws_left < 0) ws_left = (force_ws >= 0) ? force_ws : int'($urandom_range(1, 3));
        if (ws_left > 0) begin
          flash_mem_waitrequest = 1'b1;
          ws_left--;
        end else begin
          flash_mem_waitrequest = 1'b0;
          ws_left = -1;
          acc_addr = flash_mem_address[5:0];
          rdv_left = (force_rdv >= 0) ? force_rdv : int'($urandom_range(1, 4));
        end
      end else begin
        flash_mem_waitrequest = 1'b1;
        ws_left = -1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Next address by the region rules, computed as an offset within the region.
  function automatic logic [22:0] model_next(input logic [22:0] a, input bit d, input bit pend,
                                             output bit stop);
    int n;
    int off;
    n = int'(END_A) - int'(START_A) + 1;
    off = int'(a) - int'(START_A) + (d ? 1 : -1);
    stop = 1'b0;
    if (pend) return d ? START_A : END_A;
    if (off < 0 || off >= n) begin
`ifdef PLAYBACK_LOOP_EN
      off = (off + n) % n;
`else
      stop = 1'b1;
      return a;
`endif
    end
    return 23'(int'(START_A) + off);
  endfunction

  task automatic do_tick(input string tag, input logic exp_valid, input logic exp_ur);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check({tag, "_valid"}, 32'(sample_valid), 32'(exp_valid));
    check({tag, "_sample"}, 32'(sample_out), 32'(m_last));
    check({tag, "_underrun"}, 32'(underrun), 32'(exp_ur));
  endtask

  task automatic wait_read(input string tag, input logic [22:0] exp_a);
    int i;
    i = 0;
    while (!flash_mem_read && i < 60) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_read"}, 32'(flash_mem_read), 1);
    check({tag, "_addr"}, 32'(flash_mem_address), 32'(exp_a));
  endtask

  // One word: fetch check, optional underrun tick, pause, restart, dir glitch, two samples.
  task automatic play_word(input string tag, input bit ur, input int pause_ticks, input bit rst_a,
                           input bit glitch, input int newdir);
    logic [31:0] w;
    logic [15:0] h0, h1;
    logic [22:0] nxt;
    bit          stop;
    wait_read(tag, m_addr);
    if (newdir >= 0) begin
      dir = newdir[0];
      m_dir = newdir[0];
    end
    if (ur) begin
      do_tick({tag, "_ur"}, 1'b0, 1'b1);
      @(negedge clk);
      check({tag, "_ur_pulse_end"}, 32'(underrun), 0);
    end
    repeat (14) @(negedge clk);
    w = mem[m_addr[5:0]];
    h0 = m_dir ? w[15:0] : w[31:16];
    h1 = m_dir ? w[31:16] : w[15:0];
    if (pause_ticks > 0) begin
      play = 1'b0;
      for (int i = 0; i < pause_ticks; i++) begin
        do_tick({tag, "_pause"}, 1'b0, 1'b0);
        @(negedge clk);
      end
      play = 1'b1;
    end
    if (glitch) dir = ~m_dir;
    if (rst_a) begin
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      m_pend = 1'b1;
    end
    m_last = h0;
    do_tick({tag, "_a"}, 1'b1, 1'b0);
    dir = m_dir;
    m_last = h1;
    do_tick({tag, "_b"}, 1'b1, 1'b0);
    nxt = model_next(m_addr, m_dir, m_pend, stop);
    m_pend = 1'b0;
    if (stop) begin
      repeat (3) @(negedge clk);
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_idle_read"}, 32'(flash_mem_read), 0);
      check({tag, "_hold_addr"}, 32'(flash_mem_address), 32'(m_addr));
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      m_addr = m_dir ? START_A : END_A;
      check({tag, "_done_clr"}, 32'(done), 0);
      check({tag, "_rst_addr"}, 32'(flash_mem_address), 32'(m_addr));
    end else begin
      m_addr = nxt;
    end
  endtask

  initial begin
    int nd;
    reset = 1'b1;
    play = 1'b0;
    dir = 1'b1;
    restart = 1'b0;
    sample_tick = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom();
    m_addr = START_A;
    m_dir = 1'b1;
    m_pend = 1'b0;
    m_last = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_read", 32'(flash_mem_read), 0);
    check("rst_addr", 32'(flash_mem_address), 32'(START_A));
    check("rst_sample", 32'(sample_out), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_done", 32'(done), 0);
    check("byteenable", 32'(flash_mem_byteenable), 32'hF);
    reset = 1'b0;

    // Forward word at START with fixed handshake timing
    mem[0] = 32'hBEEF_1234;
    force_ws = 2;
    force_rdv = 3;
    play = 1'b1;
    play_word("t1", 1'b0, 0, 1'b0, 1'b0, -1);
    force_ws = -1;
    force_rdv = -1;

    // Underrun during fetch, then pause with ticks in TICK_A
    play_word("t_ur_pause", 1'b1, 5, 1'b0, 1'b0, -1);

    // Reset while a read is outstanding; the late data must be ignored
    force_rdv = 4;
    wait_read("rmr", m_addr);
    for (int i = 0; i < 20 && flash_mem_read; i++) @(negedge clk);
    check("rmr_drop", 32'(flash_mem_read), 0);
    play = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    force_rdv = -1;
    m_addr = START_A;
    m_last = 16'h0;
    m_pend = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("rmr_valid", 32'(sample_valid), 0);
      check("rmr_idle_read", 32'(flash_mem_read), 0);
      @(negedge clk);
    end
    check("rmr_addr", 32'(flash_mem_address), 32'(START_A));
    check("rmr_sample", 32'(sample_out), 0);

    // Backward word at START, then the word that follows it
    mem[0] = 32'hAAAA_5555;
    dir = 1'b0;
    m_dir = 1'b0;
    play = 1'b1;
    play_word("t2", 1'b0, 0, 1'b0, 1'b0, -1);
    play_word("t2b", 1'b0, 0, 1'b0, 1'b0, -1);

    // Idle restart backward lands on END, then play forward across END
    play = 1'b0;
    reset = 1'b1;
    repeat (12) @(negedge clk);
    reset = 1'b0;
    m_last = 16'h0;
    dir = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("t3_idle_restart_addr", 32'(flash_mem_address), 32'(END_A));
    dir = 1'b1;
    m_dir = 1'b1;
    m_addr = END_A;
    play = 1'b1;
    play_word("t3", 1'b0, 0, 1'b0, 1'b0, -1);

    // Restart in TICK_A: both halves still play, next read at START
    play_word("t6a", 1'b0, 0, 1'b0, 1'b0, -1);
    play_word("t6", 1'b0, 0, 1'b1, 1'b0, -1);

    // Randomized playback
    for (int k = 0; k < 80; k++) begin
      nd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
      play_word("rnd", $urandom_range(0, 99) < 25, ($urandom_range(0, 99) < 30) ? int'($urandom_range(1, 3)) : 0,
                $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 20, nd);
    end
    wait_read("final", m_addr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
